// File: rtl/mips_pkg.sv
// Shared encodings and the ID/EX register layout for the pipelined MIPS core.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_IMM  = 2'b01,
    SH_VAR  = 2'b10
  } shift_mode_e;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] signImm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  writeReg;
    logic [4:0]  shamt;
    logic [3:0]  aluControl;
    logic        aluSrc;
    logic [1:0]  shift;
    logic        regWrite;
    logic        memtoReg;
    logic        memWrite;
  } id_ex_t;

  function automatic logic [31:0] zextShamt(input logic [4:0] amt);
    return {27'b0, amt};
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 forwarding select for one 32-bit execute operand; select 11 falls back to
// the register path.
module operand_fwd_mux
  import mips_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] regVal,
  input  logic [31:0] wbVal,
  input  logic [31:0] memVal,
  output logic [31:0] out
);

  always_comb begin
    out = regVal;
    case (sel)
      FWD_WB:  out = wbVal;
      FWD_MEM: out = memVal;
      default: out = regVal;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side forwarding and shift operand selection.
// Build option: ID_EX_FORWARD_EN enables the MEM/WB forwarding muxes.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] SignImmD,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  input  logic [4:0]  ShamtD,
  input  logic [3:0]  ALUControlD,
  input  logic        ALUSrcD,
  input  logic [1:0]  ShiftD,
  input  logic        RegDstD,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ResultW,
  output logic [31:0] SrcAE,
  output logic [31:0] SrcBE,
  output logic [3:0]  ALUControlE,
  output logic [31:0] WriteDataE,
  output logic [4:0]  WriteRegE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE
);

  id_ex_t stageD;
  id_ex_t stageQ;
  logic [1:0]  selA;
  logic [1:0]  selB;
  logic [31:0] fwdA;
  logic [31:0] fwdB;

  always_comb begin
    stageD            = '0;
    stageD.rd1        = RD1D;
    stageD.rd2        = RD2D;
    stageD.signImm    = SignImmD;
    stageD.rs         = RsD;
    stageD.rt         = RtD;
    stageD.writeReg   = RegDstD ? RdD : RtD;
    stageD.shamt      = ShamtD;
    stageD.aluControl = ALUControlD;
    stageD.aluSrc     = ALUSrcD;
    stageD.shift      = ShiftD;
    stageD.regWrite   = RegWriteD;
    stageD.memtoReg   = MemtoRegD;
    stageD.memWrite   = MemWriteD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stageQ <= '0;
    end else if (FlushE) begin
      stageQ <= '0;
    end else if (!StallE) begin
      stageQ <= stageD;
    end
  end

`ifdef ID_EX_FORWARD_EN
  assign selA = ForwardAE;
  assign selB = ForwardBE;
`else
  // Forwarding disabled: the hazard unit stalls on RAW, so selects are pinned.
  logic unusedFwdSel;
  assign unusedFwdSel = ^{ForwardAE, ForwardBE};
  assign selA = FWD_RF;
  assign selB = FWD_RF;
`endif

  operand_fwd_mux uFwdA (
    .sel    (selA),
    .regVal (stageQ.rd1),
    .wbVal  (ResultW),
    .memVal (ALUOutM),
    .out    (fwdA)
  );

  operand_fwd_mux uFwdB (
    .sel    (selB),
    .regVal (stageQ.rd2),
    .wbVal  (ResultW),
    .memVal (ALUOutM),
    .out    (fwdB)
  );

  // Shifts put the shifted value (rt) on A and the amount on B.
  always_comb begin
    SrcAE = fwdA;
    SrcBE = stageQ.aluSrc ? stageQ.signImm : fwdB;
    case (stageQ.shift)
      SH_IMM: begin
        SrcAE = fwdB;
        SrcBE = zextShamt(stageQ.shamt);
      end
      SH_VAR: begin
        SrcAE = fwdB;
        SrcBE = zextShamt(fwdA[4:0]);
      end
      default: ;
    endcase
  end

  assign WriteDataE  = fwdB;
  assign ALUControlE = stageQ.aluControl;
  assign WriteRegE   = stageQ.writeReg;
  assign RsE         = stageQ.rs;
  assign RtE         = stageQ.rt;
  assign RegWriteE   = stageQ.regWrite;
  assign MemtoRegE   = stageQ.memtoReg;
  assign MemWriteE   = stageQ.memWrite;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register with execute-side operand selection for the pipelined MIPS core. It captures decode-stage operands and control at each clock edge and supports stall (hold) and flush (bubble). In the execute stage it forwards from the MEM and WB stages and applies the immediate and shift operand rules. Its outputs `SrcAE`, `SrcBE` and `ALUControlE` drive the execute ALU directly; the remaining outputs feed the EX/MEM register and the hazard unit.

## Interface
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `StallE`  in  1  hold all registered state
- `FlushE`  in  1  load a bubble
- `RD1D`, `RD2D`  in  32  register-file read data for rs and rt
- `SignImmD`  in  32  sign-extended immediate
- `RsD`, `RtD`, `RdD`  in  5  register specifiers
- `ShamtD`  in  5  instruction shift amount
- `ALUControlD`  in  4  ALU operation code
- `ALUSrcD`  in  1  operand B select: 1 = immediate
- `ShiftD`  in  2  shift operand mode: 00 none, 01 shamt, 10 variable; 11 is treated as 00
- `RegDstD`, `RegWriteD`, `MemtoRegD`, `MemWriteD`  in  1  control fields
- `ForwardAE`, `ForwardBE`  in  2  forwarding selects: 00 register, 01 `ResultW`, 10 `ALUOutM`; 11 is treated as 00
- `ALUOutM`, `ResultW`  in  32  forwarding sources
- `SrcAE`, `SrcBE`  out  32  ALU operands
- `ALUControlE`  out  4  registered ALU operation code
- `WriteDataE`  out  32  forwarded rt value, used as store data
- `WriteRegE`  out  5  destination register
- `RsE`, `RtE`  out  5  registered specifiers, for the hazard unit
- `RegWriteE`, `MemtoRegE`, `MemWriteE`  out  1  registered control fields

## Operation
- **Register update priority:** `rst_n`=0, then `FlushE`, then `StallE`, then normal load.
  - Reset: every register is cleared to 0.
  - Flush: every register is cleared to 0.
  - Stall: all registers hold their values.
  - Normal load: all D-side values are captured.
- **Bubble state.** The all-zero register state makes `RegWriteE`=`MemWriteE`=`MemtoRegE`=0, `ALUControlE`=0000 (add), `WriteRegE`=0 and `RsE`=`RtE`=0. A bubble therefore has no architectural effect.
- **Destination register.** `WriteRegE` is computed at load time as `RegDstD` ? `RdD` : `RtD` and stored; it is not recomputed in the execute stage.
- **Forwarded operands (combinational, from registered state).**
  - `fwdA` is selected from registered RD1 / `ResultW` / `ALUOutM` by `ForwardAE`.
  - `fwdB` is selected from registered RD2 / `ResultW` / `ALUOutM` by `ForwardBE`.
  - `WriteDataE` = `fwdB` in all cases.
- **Operand rules by registered shift mode.**
  - Mode 00: `SrcAE` = `fwdA`; `SrcBE` = registered ALUSrc ? SignImm : `fwdB`.
  - Mode 01: `SrcAE` = `fwdB`; `SrcBE` = {27'b0, Shamt}.
  - Mode 10: `SrcAE` = `fwdB`; `SrcBE` = {27'b0, `fwdA`[4:0]}.
  - The shift amount is always zero-extended to 32 bits and never exceeds 31.
- **Stall with changing forwarding sources.** The raw operands stay held; the forwarding muxes re-evaluate every cycle against the current `ALUOutM`/`ResultW`.

## Timing
- One cycle of latency: D-side inputs present before edge N appear on the registered outputs after edge N.
- `SrcAE`, `SrcBE` and `WriteDataE` are combinational from registered state plus `Forward*E`, `ALUOutM` and `ResultW`, with no cycle penalty.
- **Reset values:** every output is 0. Under reset `SrcAE`/`SrcBE` equal 0 only when the forwarding inputs select the register path.
- **`FlushE` and `StallE` together:** flush wins and a bubble is loaded.
- **Reset during a stall:** reset wins and all registers clear on that edge.
- **Consecutive flushes:** each flushed cycle inserts one bubble.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding muxes are present as described above.
- `ID_EX_FORWARD_EN` undefined:
  - `ForwardAE`, `ForwardBE`, `ALUOutM` and `ResultW` are ignored.
  - `fwdA` = registered RD1 and `fwdB` = registered RD2.
  - The hazard unit must stall on every RAW dependence.
  - Ports remain present so the instantiation is identical in both builds.

## Structure
- Shared package `mips_pkg` holds:
  - ALU operation codes: ALU_ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOR=0101, SLT=0110, SLL=0111, SRL=1000, SRA=1001.
  - Forward selects: FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - Shift modes: SH_NONE=00, SH_IMM=01, SH_VAR=10.
- Sub-module `operand_fwd_mux` (3:1 select, 32-bit, 11 maps to the register path) is instantiated twice, once for `fwdA` and once for `fwdB`.

## Test plan
- **Reset:** hold `rst_n`=0 with all inputs at non-zero values, forwards 00, for 2 edges. Expect all outputs = 0.
- **Add immediate:** load RD1=0x10, SignImm=0xFFFFFFFC, ALUSrc=1, ALUControl=0000. Next cycle expect `SrcAE`=0x10, `SrcBE`=0xFFFFFFFC.
- **Forwarding:** with ForwardAE=10, `ALUOutM`=0xAAAA0000, ForwardBE=01, `ResultW`=0x5, ALUSrc=0, expect `SrcAE`=0xAAAA0000, `SrcBE`=0x5, `WriteDataE`=0x5. With ForwardAE=11, expect `SrcAE` = registered RD1.
- **Shift modes:**
  - sll: Shift=01, RD2=0x1, Shamt=4 → `SrcAE`=0x1, `SrcBE`=0x4.
  - srav: Shift=10, RD1=0xFFFFFF23, RD2=0x80000000 → `SrcBE`=0x3, `SrcAE`=0x80000000.
- **Stall then flush:**
  - Load RegWrite=1, RdD=7, RegDst=1, then assert `StallE` with changed D inputs for 3 cycles: outputs hold and `WriteRegE`=7.
  - Assert `FlushE` together with `StallE`: next cycle `RegWriteE`=0, `WriteRegE`=0, `ALUControlE`=0000.
- **`ID_EX_FORWARD_EN` undefined:** ForwardAE=10, `ALUOutM`=0x1234, RD1=0x99 → `SrcAE`=0x99.
